// File: rtl/multiport_reg_file_pkg.sv
// Shared types and helpers for the multiport register file: FSM encoding,
// address-width derivation and lane indexing for the packed port vectors.
package multiport_reg_file_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int calc_addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // Low bit of lane 'lane' inside a packed vector of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/multiport_reg_file_wr_arbiter.sv
// Write-port arbiter: highest-index-wins resolution for one probe address,
// per-port keep flags for the array update and same-cycle collision detect.
module multiport_reg_file_wr_arbiter
    import multiport_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 0
) (
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]     i_wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         o_hit,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [NUM_WR-1:0]            o_wr_keep,
    output logic                         o_collision
);

    logic [ADDR_W-1:0]     w_addr [NUM_WR];
    logic [DATA_WIDTH-1:0] w_data [NUM_WR];
    logic [NUM_WR-1:0]     w_live;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_port
        assign w_addr[k] = i_wr_addr[lane_lsb(k, ADDR_W) +: ADDR_W];
        assign w_data[k] = i_wr_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
        // A write to the hardwired zero register neither lands nor competes.
        assign w_live[k] = i_wr_en[k] && !(ZERO_REG != 0 && w_addr[k] == '0);
    end

    always_comb begin
        // NOTE: every output gets a default before any conditional, so no path can infer a latch.
        o_hit       = 1'b0;
        o_data      = '0;
        o_wr_keep   = '0;
        o_collision = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            // NOTE: blocking assignments here let a later (higher-index) port overwrite an earlier hit.
            if (w_live[k] && w_addr[k] == i_addr) begin
                o_hit  = 1'b1;
                o_data = w_data[k];
            end
            o_wr_keep[k] = w_live[k];
            for (int m = k + 1; m < NUM_WR; m++) begin
                if (w_live[k] && w_live[m] && w_addr[k] == w_addr[m]) begin
                    o_wr_keep[k] = 1'b0;
                    o_collision  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// Parametrised multiport register file with write priority, collision flag,
// optional bypass / zero register and a sequential clear sweep.
module multiport_reg_file
    import multiport_reg_file_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 32,
    parameter int  NUM_WR     = 2,
    parameter int  NUM_RD     = 4,
    parameter int  BYPASS     = 1,
    parameter int  ZERO_REG   = 0,
    localparam int ADDR_W     = calc_addr_w(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_req,
    output logic                         ready,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic                         wr_collision
);

    state_e                r_state, w_state_next;
    logic [ADDR_W-1:0]     r_clr_cnt, w_clr_cnt_next;
    logic                  r_collision;
    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    logic                  w_wr_allow;
    logic [NUM_WR-1:0]     w_wr_en;
    logic [NUM_WR-1:0]     w_wr_keep;
    logic                  w_wr_collision;
    logic [ADDR_W-1:0]     w_wr_addr [NUM_WR];
    logic [DATA_WIDTH-1:0] w_wr_data [NUM_WR];
    logic [ADDR_W-1:0]     w_rd_addr [NUM_RD];
    logic [NUM_RD-1:0]     w_rd_hit;
    logic [DATA_WIDTH-1:0] w_rd_byp [NUM_RD];

    logic                  w_unused_upd_hit;
    logic [DATA_WIDTH-1:0] w_unused_upd_data;
    logic [NUM_WR-1:0]     w_unused_rd_keep [NUM_RD];
    logic [NUM_RD-1:0]     w_unused_rd_coll;

    // Writes only land in RUN, outside reset, and not in a clear-request cycle.
    assign w_wr_en = w_wr_allow ? wr_en : '0;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign w_wr_addr[k] = wr_addr[lane_lsb(k, ADDR_W) +: ADDR_W];
        assign w_wr_data[k] = wr_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
    end

    multiport_reg_file_wr_arbiter #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
    ) u_upd_arb (
        .i_wr_en(w_wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_addr('0),
        .o_hit(w_unused_upd_hit), .o_data(w_unused_upd_data),
        .o_wr_keep(w_wr_keep), .o_collision(w_wr_collision)
    );

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        assign w_rd_addr[j] = rd_addr[lane_lsb(j, ADDR_W) +: ADDR_W];
        multiport_reg_file_wr_arbiter #(
            .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
        ) u_rd_arb (
            .i_wr_en(w_wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_addr(w_rd_addr[j]),
            .o_hit(w_rd_hit[j]), .o_data(w_rd_byp[j]),
            .o_wr_keep(w_unused_rd_keep[j]), .o_collision(w_unused_rd_coll[j])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_collision <= w_wr_collision;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_wr_allow     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                if (clear_req) begin
                    w_clr_cnt_next = '0;
                end else if (r_clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                end else begin
                    w_wr_allow = !reset;
                end
            end
        endcase
    end

    // NOTE: the array has no reset branch; the clear sweep zeroes it so it stays a plain RAM-style array.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wr_keep[k]) begin
                    r_mem[w_wr_addr[k]] <= w_wr_data[k];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (r_state == ST_RUN) begin
                if (ZERO_REG != 0 && w_rd_addr[j] == '0) begin
                    rd_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = '0;
                end else if (BYPASS != 0 && w_rd_hit[j]) begin
                    rd_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = w_rd_byp[j];
                end else begin
                    rd_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = r_mem[w_rd_addr[j]];
                end
            end
        end
    end

    assign ready        = (r_state == ST_RUN);
    assign wr_collision = r_collision;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Scoreboard bench for multiport_reg_file: dut_a uses BYPASS=1/ZERO_REG=0,
// dut_b uses BYPASS=0/ZERO_REG=1; both share one stimulus stream.
module tb_multiport_reg_file;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NWR = 2;
    localparam int NRD = 4;

    typedef enum int {SIG_RD_A, SIG_RD_B, SIG_RDY_A, SIG_RDY_B, SIG_COL_A, SIG_COL_B} sig_e;
    typedef struct {
        int            cyc;
        sig_e          sig;
        int            idx;
        logic [DW-1:0] val;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic               clk       = 1'b0;
    logic               reset     = 1'b1;
    logic               clear_req = 1'b0;
    logic [NWR-1:0]     wr_en     = '0;
    logic [NWR*AW-1:0]  wr_addr   = '0;
    logic [NWR*DW-1:0]  wr_data   = '0;
    logic [NRD*AW-1:0]  rd_addr   = '0;
    logic [NRD*DW-1:0]  rd_data_a, rd_data_b;
    logic               ready_a, ready_b, col_a, col_b;

    multiport_reg_file #(.BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .wr_collision(col_a)
    );

    multiport_reg_file #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .wr_collision(col_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] observe(input sig_e s, input int idx);
        case (s)
            SIG_RD_A:  return rd_data_a[idx*DW +: DW];
            SIG_RD_B:  return rd_data_b[idx*DW +: DW];
            SIG_RDY_A: return {{(DW-1){1'b0}}, ready_a};
            SIG_RDY_B: return {{(DW-1){1'b0}}, ready_b};
            SIG_COL_A: return {{(DW-1){1'b0}}, col_a};
            SIG_COL_B: return {{(DW-1){1'b0}}, col_b};
            default:   return 'x;
        endcase
    endfunction

    // Monitor: pops every expectation due in the current cycle, away from the edge.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, observe(e.sig, e.idx), e.val);
        end
    end

    task automatic push_exp(input sig_e s, input int idx, input logic [DW-1:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = s;
        e.idx  = idx;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp_rd(input int p, input logic [DW-1:0] va, input logic [DW-1:0] vb, input string tag);
        push_exp(SIG_RD_A, p, va, $sformatf("%s rd%0d dut_a", tag, p));
        push_exp(SIG_RD_B, p, vb, $sformatf("%s rd%0d dut_b", tag, p));
    endtask

    task automatic exp_status(input logic rdy, input logic ca, input logic cb, input string tag);
        push_exp(SIG_RDY_A, 0, DW'(rdy), {tag, " ready dut_a"});
        push_exp(SIG_RDY_B, 0, DW'(rdy), {tag, " ready dut_b"});
        push_exp(SIG_COL_A, 0, DW'(ca),  {tag, " collision dut_a"});
        push_exp(SIG_COL_B, 0, DW'(cb),  {tag, " collision dut_b"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    // Full sweep after reset release: ready low for NR cycles, reads zero, writes ignored.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < NR; i++) begin
            set_wr(0, AW'((i + NR - 1) % NR), 32'hBAD0_0000 | i);
            set_wr(1, '0, 32'h5A5A_0000 | i);
            set_rd(0, AW'((i + NR - 1) % NR));
            for (int j = 1; j < NRD; j++) set_rd(j, AW'((i + j * 8) % NR));
            exp_status(1'b0, 1'b0, 1'b0, $sformatf("%s c%0d", tag, i));
            for (int j = 0; j < NRD; j++) exp_rd(j, '0, '0, $sformatf("%s c%0d", tag, i));
            tick();
        end
        wr_en = '0;
        exp_status(1'b1, 1'b0, 1'b0, {tag, " done"});
    endtask

    task automatic read_all_zero(input string tag);
        for (int base = 0; base < NR; base += NRD) begin
            for (int j = 0; j < NRD; j++) set_rd(j, AW'(base + j));
            for (int j = 0; j < NRD; j++) exp_rd(j, '0, '0, $sformatf("%s r%0d", tag, base + j));
            tick();
        end
    endtask

    initial begin
        tick();
        exp_status(1'b0, 1'b0, 1'b0, "reset");
        tick();
        tick();
        reset = 1'b0;
        sweep_check("sweep0");
        tick();
        read_all_zero("post_sweep0");

        // Basic write/read on both ports.
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        set_wr(1, 5'd9, 32'h1234_5678);
        set_rd(0, 5'd5); set_rd(1, 5'd9); set_rd(2, 5'd5); set_rd(3, 5'd0);
        exp_rd(0, 32'hDEAD_BEEF, '0, "basic_same");
        exp_rd(1, 32'h1234_5678, '0, "basic_same");
        exp_rd(2, 32'hDEAD_BEEF, '0, "basic_same");
        exp_rd(3, '0, '0, "basic_same");
        tick();
        wr_en = '0;
        exp_rd(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "basic_next");
        exp_rd(1, 32'h1234_5678, 32'h1234_5678, "basic_next");
        exp_rd(2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "basic_next");
        exp_rd(3, '0, '0, "basic_next");
        exp_status(1'b1, 1'b0, 1'b0, "basic_next");
        tick();

        // Collision on r7: port1 must win, flag pulses for one cycle.
        set_wr(0, 5'd7, 32'h1);
        set_wr(1, 5'd7, 32'h2);
        set_rd(0, 5'd7); set_rd(1, 5'd5); set_rd(2, 5'd9); set_rd(3, 5'd7);
        exp_rd(0, 32'h2, '0, "coll_same");
        exp_rd(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "coll_same");
        exp_rd(2, 32'h1234_5678, 32'h1234_5678, "coll_same");
        exp_rd(3, 32'h2, '0, "coll_same");
        exp_status(1'b1, 1'b0, 1'b0, "coll_same");
        tick();
        wr_en = '0;
        exp_rd(0, 32'h2, 32'h2, "coll_next");
        exp_rd(3, 32'h2, 32'h2, "coll_next");
        exp_status(1'b1, 1'b1, 1'b1, "coll_next");
        tick();
        exp_status(1'b1, 1'b0, 1'b0, "coll_after");
        tick();

        // Bypass: r3 = 0xA, then write 0xB and read in the same cycle.
        set_wr(0, 5'd3, 32'hA);
        set_rd(0, 5'd3);
        exp_rd(0, 32'hA, '0, "byp_fill");
        tick();
        wr_en = '0;
        exp_rd(0, 32'hA, 32'hA, "byp_hold");
        tick();
        set_wr(1, 5'd3, 32'hB);
        exp_rd(0, 32'hB, 32'hA, "byp_same");
        tick();
        wr_en = '0;
        exp_rd(0, 32'hB, 32'hB, "byp_next");
        tick();

        // Zero register: both ports hit r0.
        set_wr(0, 5'd0, 32'hFFFF);
        set_wr(1, 5'd0, 32'h1234);
        set_rd(0, 5'd0);
        exp_rd(0, 32'h1234, '0, "zero_same");
        tick();
        wr_en = '0;
        exp_rd(0, 32'h1234, '0, "zero_next");
        exp_status(1'b1, 1'b1, 1'b0, "zero_next");
        tick();
        exp_status(1'b1, 1'b0, 1'b0, "zero_after");
        tick();

        // Fill r1..r31 with nonzero data.
        for (int i = 1; i < NR; i++) begin
            wr_en = '0;
            set_wr(i % 2, AW'(i), 32'hC0DE_0000 | i);
            tick();
        end
        wr_en = '0;
        set_rd(0, 5'd1); set_rd(1, 5'd16); set_rd(2, 5'd31); set_rd(3, 5'd0);
        exp_rd(0, 32'hC0DE_0001, 32'hC0DE_0001, "fill");
        exp_rd(1, 32'hC0DE_0010, 32'hC0DE_0010, "fill");
        exp_rd(2, 32'hC0DE_001F, 32'hC0DE_001F, "fill");
        exp_rd(3, 32'h1234, '0, "fill");
        tick();

        // Clear request with a write in the same cycle, then reset 10 cycles in.
        clear_req = 1'b1;
        set_wr(0, 5'd2, 32'hFFFF_FFFF);
        exp_rd(0, 32'hC0DE_0001, 32'hC0DE_0001, "clrreq_cycle");
        exp_status(1'b1, 1'b0, 1'b0, "clrreq_cycle");
        tick();
        clear_req = 1'b0;
        wr_en     = '0;
        for (int i = 0; i < 10; i++) begin
            exp_status(1'b0, 1'b0, 1'b0, $sformatf("clr_sweep c%0d", i));
            for (int j = 0; j < NRD; j++) exp_rd(j, '0, '0, $sformatf("clr_sweep c%0d", i));
            tick();
        end
        reset = 1'b1;
        exp_status(1'b0, 1'b0, 1'b0, "mid_reset");
        tick();
        reset = 1'b0;
        sweep_check("sweep1");
        tick();
        read_all_zero("post_sweep1");

        @(negedge clk);
        check("scoreboard_drain", DW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiport_reg_file.md
Name: multiport_reg_file

Overview:
- Clocked, parametrised successor of the 2-write/4-read register file.
- Configurable data width, depth and number of write and read ports.
- Adds:
  - a deterministic write-collision priority and a collision flag;
  - optional write-to-read bypass and an optional hardwired-zero register 0;
  - a sequential clear engine that sweeps the array after reset or on request, with a ready status.
- Sits between the decode/issue stage (readers) and the writeback stage (writers) of the dual-issue pipeline.

Parameters:
- DATA_WIDTH, 32, width of each register.
- NUM_REGS, 32, register count; must be a power of 2 and ≥ 2.
- ADDR_W, $clog2(NUM_REGS), address width; derived, never overridden.
- NUM_WR, 2, number of write ports (1..4).
- NUM_RD, 4, number of read ports (1..8).
- BYPASS, 1, 1 = a read of an address written in the same cycle returns the write data.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset.
- clear_req  in  1  one-cycle pulse that restarts the clear sweep.
- ready  out  1  1 = array initialised; reads and writes are valid.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WR*DATA_WIDTH  packed write data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses.
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data (combinational).
- wr_collision  out  1  registered flag: two or more enabled write ports targeted the same address in the previous cycle.

Behaviour:
- Reset: reset reset, synchronous, active-high.
- Storage: NUM_REGS x DATA_WIDTH array, updated only on the rising edge of clk.
- FSM states CLEAR and RUN.
  - Reset → CLEAR. Clear counter = 0, ready = 0, wr_collision = 0.
  - CLEAR: writes 0 to array[counter] each cycle, then increments the counter.
  - CLEAR → RUN on the cycle that clears address NUM_REGS-1. ready rises on the following edge, i.e. exactly NUM_REGS cycles after reset deasserts.
  - While in CLEAR:
    - wr_en is ignored;
    - rd_data reads all zeros regardless of address or bypass;
    - wr_collision is held at 0.
  - RUN: clear_req = 1 → CLEAR with counter = 0 and ready = 0 on the next edge. A write presented in that same cycle is dropped.
  - clear_req during CLEAR restarts the counter at 0.
  - Reset mid-sweep restarts the sweep; reset has priority over clear_req.
- Writes (RUN only):
  - Every enabled port updates its address on the edge.
  - Same address on several enabled ports: the highest-indexed port wins.
  - wr_collision is registered: 1 in the cycle after any such conflict, else 0. It is a one-cycle pulse per conflicting cycle.
  - ZERO_REG = 1: writes to address 0 are discarded, and a port targeting address 0 does not count towards a collision.
- Reads (combinational):
  - rd_data[j] = array[rd_addr[j]].
  - BYPASS = 1: if any enabled write port matches rd_addr[j] this cycle, return the data of the winning (highest-index) port instead.
  - ZERO_REG = 1: address 0 always returns 0, overriding bypass.
- No out-of-range addresses exist, because NUM_REGS is a power of 2.

Decomposition:
- Shared package holds:
  - the ADDR_W computation as a function;
  - the FSM state encoding (CLEAR = 1'b0, RUN = 1'b1);
  - the pack/unpack index helpers for the port vectors.
- One sub-module, wr_arbiter.
  - Function: for a given address, returns the hit flag and winning data across all write ports.
  - Instantiation: one instance per read port for bypass, one instance for array update.
  - The collision detect also lives here.

Test Plan:
- Clear timing:
  - Stimulus: assert reset 3 cycles, then release; NUM_REGS = 32.
  - Response: ready = 0 for 32 cycles, then 1. All 4 read ports return 0 on every address.
  - Writes attempted during the sweep leave no trace.
- Basic write/read:
  - Stimulus: port0 writes 0xDEADBEEF to r5; port1 writes 0x12345678 to r9.
  - Response: next cycle, rd ports 0..3 with addresses {5,9,5,0} read {0xDEADBEEF, 0x12345678, 0xDEADBEEF, 0}.
- Collision:
  - Stimulus: both ports write r7 (port0 = 0x1, port1 = 0x2).
  - Response: r7 = 0x2 afterwards. wr_collision = 1 for exactly one cycle, then 0.
  - With BYPASS = 1, a same-cycle read of r7 returns 0x2.
- Bypass:
  - Stimulus: BYPASS = 1; r3 holds 0xA; write 0xB to r3 and read r3 in the same cycle.
  - Response: rd_data = 0xB.
  - With BYPASS = 0 the same stimulus returns 0xA, then 0xB on the next cycle.
- Zero register:
  - Stimulus: ZERO_REG = 1; write 0xFFFF to r0 on port0 and r0 on port1 in the same cycle.
  - Response: r0 reads 0; wr_collision stays 0.
- Clear request mid-run and reset mid-sweep:
  - Stimulus: fill r1..r31 with nonzero data, then pulse clear_req. Next, 10 cycles into the sweep, assert reset for 1 cycle.
  - Response: ready low, and the sweep restarts. ready rises 32 cycles after reset deasserts, and all registers then read 0.
